// File: rtl/ipgu_pkg.sv
// Shared IPGU definitions: default frame geometry, writer FSM states and the
// half-width {Y,X} address type used on both sides of the image RAM.
package ipgu_pkg;

    localparam int IPGU_IMG_W          = 240;
    localparam int IPGU_IMG_H          = 240;
    localparam int IPGU_RAM_ADDR_WIDTH = 18;

    typedef logic [IPGU_RAM_ADDR_WIDTH/2-1:0] addr_half_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } ipgu_wr_state_t;

endpackage

// File: rtl/ipgu_raster_counter.sv
// Raster-order X/Y position counter: X runs fastest and wraps into Y.
// 'last' flags the final pixel of the frame at the current position.
module ipgu_raster_counter
    import ipgu_pkg::*;
#(
    parameter int CNT_W = IPGU_RAM_ADDR_WIDTH/2,
    parameter int IMG_W = IPGU_IMG_W,
    parameter int IMG_H = IPGU_IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             last
);

    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(IMG_H - 1);

    logic x_end;
    logic y_end;

    assign x_end = (x == X_MAX);
    assign y_end = (y == Y_MAX);
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ipgu_ram_writer.sv
// Writes a raster pixel stream into the IPGU image RAM as {Y,X}-addressed
// writes and hands each finished frame to the window reader.
module ipgu_ram_writer
    import ipgu_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = IPGU_RAM_ADDR_WIDTH,
    parameter int IMG_W          = IPGU_IMG_W,
    parameter int IMG_H          = IPGU_IMG_H,
    parameter int PIX_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pixValid,
    input  logic [PIX_W-1:0]          pixData,
    output logic                      pixReady,
    input  logic                      ramStall,
    output logic                      wrEn,
    output logic [RAM_ADDR_WIDTH-1:0] wrAddr,
    output logic [PIX_W-1:0]          wrData,
    output logic                      busy,
    output logic                      frameDone,
    output logic                      frameReady,
    input  logic                      frameAck
);

    localparam int HALF_W = RAM_ADDR_WIDTH / 2;

    ipgu_wr_state_t    state;
    ipgu_wr_state_t    state_nx;
    logic [HALF_W-1:0] addr_x;
    logic [HALF_W-1:0] addr_y;
    logic              cnt_last;
    logic              last_accepted;
    logic              frame_start;
    logic              accept;
    logic              wr_complete;

    assign frame_start = start && ((state == IDLE) || ((state == DONE) && frameAck));
    assign accept      = pixValid && pixReady;
    assign wr_complete = wrEn && !ramStall;

    ipgu_raster_counter #(
        .CNT_W (HALF_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start),
        .inc  (accept),
        .x    (addr_x),
        .y    (addr_y),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Once the final pixel is taken, the only pending write is the last one,
    // so its completion ends the frame.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = WRITE;
            WRITE:   if (last_accepted && wr_complete) state_nx = DONE;
            DONE:    if (frameAck) state_nx = start ? WRITE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pixReady   = 1'b0;
        busy       = 1'b0;
        frameReady = 1'b0;
        pixReady   = (state == WRITE) && !last_accepted && (!wrEn || !ramStall);
        busy       = (state != IDLE);
        frameReady = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            last_accepted <= 1'b0;
        end else if (accept && cnt_last) begin
            last_accepted <= 1'b1;
        end
    end

    // Write register: load on accept, retire on completion, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= (state == WRITE) && (state_nx == DONE);
            if (accept) begin
                wrEn   <= 1'b1;
                wrAddr <= {addr_y, addr_x};
                wrData <= pixData;
            end else if (wr_complete) begin
                wrEn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ipgu_ram_writer.sv
// Directed + randomized bench for ipgu_ram_writer: a pixel-index scoreboard
// derives every expected {Y,X} address and data value from raster order.
module tb_ipgu_ram_writer;

    // Short frame keeps four full frames well inside the cycle budget while
    // still covering X=57, the Y=4->5 wrap and pixel (100,10).
    localparam int IMG_W = 240;
    localparam int IMG_H = 24;
    localparam int N     = IMG_W * IMG_H;
    localparam int AW    = 18;
    localparam int HW    = AW / 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          pixValid;
    logic [7:0]    pixData;
    logic          pixReady;
    logic          ramStall;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [7:0]    wrData;
    logic          busy;
    logic          frameDone;
    logic          frameReady;
    logic          frameAck;

    ipgu_ram_writer #(
        .RAM_ADDR_WIDTH (AW),
        .IMG_W          (IMG_W),
        .IMG_H          (IMG_H),
        .PIX_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pixValid   (pixValid),
        .pixData    (pixData),
        .pixReady   (pixReady),
        .ramStall   (ramStall),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .busy       (busy),
        .frameDone  (frameDone),
        .frameReady (frameReady),
        .frameAck   (frameAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [7:0]    pix_mem [N];
    int            acc_idx, wr_idx, done_cnt, wren_cyc;
    bit            mon_en = 0;
    bit            held_chk = 0;
    logic [AW-1:0] h_addr;
    logic [7:0]    h_data;
    bit            f1, f2;

    function automatic logic [AW-1:0] exp_addr(input int n);
        logic [HW-1:0] ey, ex;
        ey = HW'(n / IMG_W);
        ex = HW'(n % IMG_W);
        return {ey, ex};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: inputs are stable here, so what it sees is what the
    // next rising edge will act on.
    always @(negedge clk) begin
        if (mon_en) begin
            if (held_chk) begin
                chk("hold_wren", 32'(wrEn), 32'd1);
                chk("hold_addr", 32'(wrAddr), 32'(h_addr));
                chk("hold_data", 32'(wrData), 32'(h_data));
            end
            held_chk = wrEn && ramStall;
            h_addr   = wrAddr;
            h_data   = wrData;
            if (wrEn) wren_cyc++;
            if (wrEn && ramStall) chk("ready_in_stall", 32'(pixReady), 32'd0);
            if (wrEn && !ramStall) begin
                if (wr_idx < N) begin
                    chk("wr_addr", 32'(wrAddr), 32'(exp_addr(wr_idx)));
                    chk("wr_data", 32'(wrData), 32'(pix_mem[wr_idx]));
                end else begin
                    chk("extra_write", 32'(wr_idx), 32'(N - 1));
                end
                wr_idx++;
            end
            if (pixValid && pixReady) begin
                if (acc_idx >= N) chk("ready_after_last", 32'(acc_idx), 32'(N - 1));
                acc_idx++;
            end
            if (frameDone) begin
                done_cnt++;
                chk("done_before_last_write", 32'(wr_idx), 32'(N));
            end
        end
    end

    task automatic drive(input bit v, input bit s);
        pixValid = v;
        ramStall = s;
        pixData  = (acc_idx < N) ? pix_mem[acc_idx] : 8'h00;
    endtask

    task automatic begin_frame(input bit ack);
        mon_en = 0;
        foreach (pix_mem[i]) pix_mem[i] = 8'($urandom);
        acc_idx = 0; wr_idx = 0; done_cnt = 0; wren_cyc = 0; held_chk = 0;
        @(posedge clk); #1;
        start = 1'b1; frameAck = ack; pixValid = 1'b0; ramStall = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; frameAck = 1'b0;
        mon_en = 1;
    endtask

    task automatic run_frame(input int vpct, input int spct, input bit special);
        int cyc;
        int force_cnt;
        bit s;
        cyc = 0; force_cnt = 0; f1 = 0; f2 = 0;
        forever begin
            @(posedge clk); #1;
            if (frameReady) break;
            cyc++;
            if (cyc > 20 * N) begin
                total++; bad++;
                $error("FAIL frame_timeout: observed=%0d writes expected=%0d", wr_idx, N);
                break;
            end
            if (special && wrEn && force_cnt == 0) begin
                if (!f1 && wrAddr == exp_addr(2 * IMG_W + 57)) begin f1 = 1; force_cnt = 3; end
                if (!f2 && wrAddr == exp_addr(N - 1))          begin f2 = 1; force_cnt = 3; end
            end
            s = (force_cnt > 0) ? 1'b1 : ($urandom_range(99) < spct);
            if (force_cnt > 0) force_cnt--;
            drive($urandom_range(99) < vpct, s);
        end
        pixValid = 1'b0;
        ramStall = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wrEn"},       32'(wrEn),       32'd0);
        chk({tag, "_wrAddr"},     32'(wrAddr),     32'd0);
        chk({tag, "_wrData"},     32'(wrData),     32'd0);
        chk({tag, "_pixReady"},   32'(pixReady),   32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_frameDone"},  32'(frameDone),  32'd0);
        chk({tag, "_frameReady"}, 32'(frameReady), 32'd0);
    endtask

    task automatic check_frame_end(input string tag);
        @(negedge clk); #1;
        chk({tag, "_writes"},     32'(wr_idx),     32'(N));
        chk({tag, "_accepts"},    32'(acc_idx),    32'(N));
        chk({tag, "_done_count"}, 32'(done_cnt),   32'd1);
        chk({tag, "_frameReady"}, 32'(frameReady), 32'd1);
        chk({tag, "_pixReady"},   32'(pixReady),   32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; frameAck = 1'b0;
        pixValid = 1'b0; ramStall = 1'b0; pixData = 8'h00;
        acc_idx = 0; wr_idx = 0; done_cnt = 0; wren_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full-rate frame, no stalls: one write per clock.
        begin_frame(1'b0);
        run_frame(100, 0, 1'b0);
        check_frame_end("nostall");
        chk("nostall_wren_cycles", 32'(wren_cyc), 32'(N));

        // start without frameAck while DONE must be ignored.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ignored_frameReady", 32'(frameReady), 32'd1);
        chk("start_ignored_pixReady",   32'(pixReady),   32'd0);
        chk("start_ignored_frameDone",  32'(frameDone),  32'd0);

        // frameAck && start: straight back into WRITE; forced stalls at X=57
        // and on the final pixel.
        begin_frame(1'b1);
        chk("ackstart_busy",       32'(busy),       32'd1);
        chk("ackstart_frameReady", 32'(frameReady), 32'd0);
        chk("ackstart_pixReady",   32'(pixReady),   32'd1);
        run_frame(100, 0, 1'b1);
        check_frame_end("stalls");
        chk("stalls_injected", 32'({f1, f2}), 32'b11);

        // Reset while a write to (100,10) is stalled.
        begin_frame(1'b1);
        cyc = 0;
        forever begin
            @(posedge clk); #1;
            if (wrEn && wrAddr == exp_addr(10 * IMG_W + 100)) break;
            cyc++;
            if (cyc > 4 * N) begin
                total++; bad++;
                $error("FAIL reach_pixel_timeout: observed=%0d writes expected=%0d", wr_idx, 10 * IMG_W + 100);
                break;
            end
            drive(1'b1, 1'b0);
        end
        drive(1'b1, 1'b1);
        @(posedge clk); #1;
        chk("midreset_held_wren", 32'(wrEn), 32'd1);
        mon_en = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst = 1'b0;
        pixValid = 1'b0;
        ramStall = 1'b0;

        // Restart from IDLE with random input gaps and RAM stalls.
        begin_frame(1'b0);
        run_frame(50, 30, 1'b0);
        check_frame_end("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
